// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// A divide by zero completes in one cycle with Quotient=all ones and Remainder=dividend.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is accepted on any rising edge where Busy=0 (the cycle
  // carrying Done=1 included); Busy stays high until the edge that raises the
  // one-cycle Done pulse, and starts seen while Busy=1 are dropped.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remo_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   shift_rem;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // Shifted partial remainder can reach 2*divisor-1, so it keeps an extra bit;
  // the trial gets one more bit again so its MSB is a clean sign.
  always_comb begin
    shift_rem = {rem_q, dvd_q[WIDTH-1]};
    trial     = {1'b0, shift_rem} - {2'b00, dvs_q};
    trial_neg = trial[WIDTH+1];
    rem_d     = trial_neg ? shift_rem[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_d     = {dvd_q[WIDTH-2:0], ~trial_neg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            dvd_q  <= i1;
            rem_q  <= '0;
            if (i2 != '0) begin
              dvs_q   <= i2;
              cnt_q   <= CW'(WIDTH);
              state_q <= CALC;
            end else begin
              dvs_q   <= '0;
              state_q <= ZERO;
            end
          end
        end
        CALC: begin
          // Quotient bits enter dvd_q from the LSB as dividend bits leave the MSB.
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quot_q  <= dvd_d;
            remo_q  <= rem_d;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ZERO: begin
          quot_q  <= '1;
          remo_q  <= dvd_q;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Quotient    = quot_q;
  assign Remainder   = remo_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign DivByZero   = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
// Bench for seq_divider: directed scenarios plus random pairs, results checked
// through an expected-result queue filled when each request is driven.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] i1 = '0;
  logic [W-1:0] i2 = '0;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Each entry is {DivByZero, Quotient, Remainder}.
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_exp;

  logic         prev_busy = 1'b0;
  logic         prev_done = 1'b0;
  logic [2*W:0] prev_res  = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .i1          (i1),
    .i2          (i2),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Busy        (Busy),
    .Done        (Done),
    .DivByZero   (DivByZero),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard and protocol monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (Done) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL sb_unexpected_done: Done=1 got q=%0d r=%0d, required no Done (nothing outstanding)",
                   Quotient, Remainder);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({DivByZero, Quotient, Remainder} !== mon_exp) begin
            fail_cnt++;
            $display("FAIL sb_result: got dbz=%0b q=%0d r=%0d, required dbz=%0b q=%0d r=%0d",
                     DivByZero, Quotient, Remainder, mon_exp[2*W], mon_exp[2*W-1:W], mon_exp[W-1:0]);
          end
        end
        tests_run++;
        if (!(prev_busy && !Busy) || prev_done) begin
          fail_cnt++;
          $display("FAIL protocol_done: got prev_busy=%0b busy=%0b prev_done=%0b, required 1/0/0",
                   prev_busy, Busy, prev_done);
        end
      end else begin
        tests_run++;
        if ({DivByZero, Quotient, Remainder} !== prev_res) begin
          fail_cnt++;
          $display("FAIL result_hold: got %h, required unchanged %h without Done",
                   {DivByZero, Quotient, Remainder}, prev_res);
        end
      end
    end
    prev_busy <= Busy;
    prev_done <= Done;
    prev_res  <= {DivByZero, Quotient, Remainder};
  end

  // ---------------- driver ----------------
  // Entered at a negedge; returns at the negedge where Done is seen (or the bound expires).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_err);
    logic [2*W:0] e;
    if (b == '0) e = {1'b1, {W{1'b1}}, a};
    else         e = {1'b0, a / b, a % b};
    i1 = a;
    i2 = b;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    i1 = W'($urandom);
    i2 = W'($urandom);
    lat = 0;
    busy_err = 0;
    while (lat < 3 * W) begin
      if (!Busy) busy_err++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (Done) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({Quotient, Remainder, Busy, Done, DivByZero, dbg_state} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_state: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b st=%0d, required all 0",
               Quotient, Remainder, Busy, Done, DivByZero, dbg_state);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, be;
    run_div(8'd100, 8'd7, lat, be);
    tests_run++;
    if (lat != W) begin
      fail_cnt++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, W);
    end
    tests_run++;
    if (be != 0) begin
      fail_cnt++;
      $display("FAIL basic_busy: got %0d cycles with Busy=0, required 0", be);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, be;
    logic [W-1:0] a_tab [3];
    logic [W-1:0] b_tab [3];
    a_tab = '{8'd255, 8'd5, 8'd200};
    b_tab = '{8'd1, 8'd9, 8'd200};
    for (int k = 0; k < 3; k++) begin
      run_div(a_tab[k], b_tab[k], lat, be);
      tests_run++;
      if (lat != W || be != 0) begin
        fail_cnt++;
        $display("FAIL b2b_latency_%0d: got lat=%0d busy_err=%0d, required lat=%0d busy_err=0",
                 k, lat, be, W);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, be;
    run_div(8'd42, 8'd0, lat, be);
    tests_run++;
    if (lat != 1) begin
      fail_cnt++;
      $display("FAIL dbz_latency: got %0d, required 1", lat);
    end
    tests_run++;
    if ({DivByZero, Quotient, Remainder} !== {1'b1, 8'hFF, 8'd42}) begin
      fail_cnt++;
      $display("FAIL dbz_result: got dbz=%0b q=%0d r=%0d, required dbz=1 q=255 r=42",
               DivByZero, Quotient, Remainder);
    end
    run_div(8'd9, 8'd3, lat, be);
    tests_run++;
    if (lat != W || DivByZero !== 1'b0 || Quotient !== 8'd3) begin
      fail_cnt++;
      $display("FAIL dbz_recover: got lat=%0d dbz=%0b q=%0d, required lat=%0d dbz=0 q=3",
               lat, DivByZero, Quotient, W);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int done_cnt = 0;
    i1 = 8'd60;
    i2 = 8'd4;
    start = 1'b1;
    exp_q.push_back({1'b0, 8'd15, 8'd0});
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      i1 = 8'd99;
      i2 = 8'd9;
      start = 1'b1;
      if (Done) done_cnt++;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin
      if (Done) done_cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (done_cnt != 1 || Quotient !== 8'd15 || Remainder !== 8'd0) begin
      fail_cnt++;
      $display("FAIL ignored_start: got dones=%0d q=%0d r=%0d, required dones=1 q=15 r=0",
               done_cnt, Quotient, Remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat, be;
    logic done_seen = 1'b0;
    i1 = 8'd250;
    i2 = 8'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({Quotient, Remainder, Busy, Done, DivByZero, dbg_state} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mid_async: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b st=%0d, required all 0",
               Quotient, Remainder, Busy, Done, DivByZero, dbg_state);
    end
    repeat (3) begin
      @(negedge clk);
      done_seen |= Done;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      done_seen |= Done;
    end
    tests_run++;
    if (done_seen !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_mid_no_done: got Done seen=%0b, required 0", done_seen);
    end
    run_div(8'd250, 8'd3, lat, be);
    tests_run++;
    if (lat != W || Quotient !== 8'd83 || Remainder !== 8'd1) begin
      fail_cnt++;
      $display("FAIL reset_mid_rerun: got lat=%0d q=%0d r=%0d, required lat=%0d q=83 r=1",
               lat, Quotient, Remainder, W);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, be;
    logic [W-1:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 7));
      else                           b = W'($urandom_range(1, 255));
      run_div(a, b, lat, be);
      tests_run++;
      if (lat != W || be != 0) begin
        fail_cnt++;
        $display("FAIL rand_timing %0d/%0d: got lat=%0d busy_err=%0d, required lat=%0d busy_err=0",
                 a, b, lat, be, W);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL sb_drain: got %0d results outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
